alarm_ctrl: RTL and testbench

Alarm controller downstream of `digital_clock`, taking over the inline hour/minute compare in the top level. It holds the alarm time, which the user edits with debounced pulses. It runs an arm/ring/snooze state machine against the live `hr`/`min`/`sec`, and drives a gated buzzer tone. `alm_hr`/`alm_min` feed `bin2bcd` so the alarm time can be shown on the seven-segment display.

---
 rtl/alarm_pkg.sv | 35 +++
 rtl/alarm_tone_gen.sv | 36 +++
 rtl/alarm_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: state encoding, time limits
// and wrap-around increment helpers used by the alarm-time editor.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_t;

    localparam logic [4:0] HR_MAX  = 5'd23;
    localparam logic [5:0] MIN_MAX = 6'd59;

    function automatic logic [4:0] hr_inc(input logic [4:0] h);
        logic [4:0] r;
        if (h >= HR_MAX) begin
            r = 5'd0;
        end else begin
            r = h + 5'd1;
        end
        return r;
    endfunction

    function automatic logic [5:0] min_inc(input logic [5:0] m);
        logic [5:0] r;
        if (m >= MIN_MAX) begin
            r = 6'd0;
        end else begin
            r = m + 6'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// Square-wave tone source: toggles every TONE_DIV enabled cycles and is
// held (counter and tone both at 0) whenever the enable is low.
module alarm_tone_gen #(
    parameter int unsigned TONE_DIV = 25000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tone
);

    localparam int unsigned CNT_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TONE_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             tone_r;

    // Half-period counter and tone flip-flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= '0;
            tone_r <= 1'b0;
        end else if (!en) begin
            cnt_r  <= '0;
            tone_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r  <= '0;
            tone_r <= ~tone_r;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
        end
    end

    assign tone = tone_r;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: holds the editable alarm time, runs the arm/ring/snooze
// state machine against the live clock and gates the buzzer tone.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned TONE_DIV     = 25000,
    parameter int unsigned RING_MAX_SEC = 60,
    parameter int unsigned SNOOZE_MIN   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] hr,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       set_mode,
    input  logic       inc_hr_p,
    input  logic       inc_min_p,
    input  logic       arm,
    input  logic       snooze_p,
    input  logic       stop_p,
    output logic [4:0] alm_hr,
    output logic [5:0] alm_min,
    output logic       ringing,
    output logic       snoozed,
    output logic       buzzer
);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [4:0] alm_hr_r;
    logic [5:0] alm_min_r;
    logic [4:0] snz_hr_r;
    logic [5:0] snz_min_r;
    logic       match_d_r;
    logic [5:0] sec_d_r;
    logic [7:0] sec_cnt_r;

    logic [4:0] tgt_hr_s;
    logic [5:0] tgt_min_s;
    logic       match_s;
    logic       trig_s;
    logic       edit_s;
    logic       sec_chg_s;
    logic       ring_done_s;
    logic [6:0] min_sum_s;
    logic [4:0] snz_hr_s;
    logic [5:0] snz_min_s;
    logic       ringing_s;
    logic       snoozed_s;
    logic       tone_s;

    assign edit_s      = set_mode & (inc_hr_p | inc_min_p);
    assign sec_chg_s   = (sec != sec_d_r);
    assign ring_done_s = (sec_cnt_r >= 8'(RING_MAX_SEC));
    assign match_s     = (hr == tgt_hr_s) && (min == tgt_min_s);
    assign trig_s      = match_s & ~match_d_r & ~set_mode;

    // Compare target: snooze time while snoozed, alarm time otherwise
    always_comb begin
        tgt_hr_s  = alm_hr_r;
        tgt_min_s = alm_min_r;
        if (state_r == ST_SNOOZE) begin
            tgt_hr_s  = snz_hr_r;
            tgt_min_s = snz_min_r;
        end else begin
            tgt_hr_s  = alm_hr_r;
            tgt_min_s = alm_min_r;
        end
    end

    // Snooze target = now + SNOOZE_MIN, minute carry into a mod-24 hour
    always_comb begin
        min_sum_s = {1'b0, min} + 7'(SNOOZE_MIN);
        snz_hr_s  = hr;
        snz_min_s = min_sum_s[5:0];
        if (min_sum_s > {1'b0, MIN_MAX}) begin
            snz_min_s = 6'(min_sum_s - 7'd60);
            snz_hr_s  = hr_inc(hr);
        end else begin
            snz_min_s = min_sum_s[5:0];
            snz_hr_s  = hr;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; disarm wins, then stop, then snooze, then auto-stop
    always_comb begin
        state_nxt_s = state_r;
        if (!arm) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_ARMED;
                ST_ARMED: begin
                    if (trig_s) begin
                        state_nxt_s = ST_RINGING;
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
                ST_RINGING: begin
                    if (stop_p) begin
                        state_nxt_s = ST_ARMED;
                    end else if (snooze_p) begin
                        state_nxt_s = ST_SNOOZE;
                    end else if (ring_done_s) begin
                        state_nxt_s = ST_ARMED;
                    end else begin
                        state_nxt_s = ST_RINGING;
                    end
                end
                ST_SNOOZE: begin
                    if (stop_p || edit_s) begin
                        state_nxt_s = ST_ARMED;
                    end else if (trig_s) begin
                        state_nxt_s = ST_RINGING;
                    end else begin
                        state_nxt_s = ST_SNOOZE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Output decode from the state register
    always_comb begin
        ringing_s = 1'b0;
        snoozed_s = 1'b0;
        case (state_r)
            ST_RINGING: ringing_s = 1'b1;
            ST_SNOOZE:  snoozed_s = 1'b1;
            default: begin
                ringing_s = 1'b0;
                snoozed_s = 1'b0;
            end
        endcase
    end

    // Alarm time editor
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alm_hr_r  <= 5'd0;
            alm_min_r <= 6'd0;
        end else begin
            if (set_mode && inc_hr_p) begin
                alm_hr_r <= hr_inc(alm_hr_r);
            end
            if (set_mode && inc_min_p) begin
                alm_min_r <= min_inc(alm_min_r);
            end
        end
    end

    // Snooze target latch on the RINGING to SNOOZE transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snz_hr_r  <= 5'd0;
            snz_min_r <= 6'd0;
        end else if (state_r == ST_RINGING && state_nxt_s == ST_SNOOZE) begin
            snz_hr_r  <= snz_hr_s;
            snz_min_r <= snz_min_s;
        end
    end

    // Match edge history and ring-duration second counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_d_r <= 1'b1;
            sec_d_r   <= 6'd0;
            sec_cnt_r <= 8'd0;
        end else begin
            match_d_r <= match_s;
            sec_d_r   <= sec;
            if (state_nxt_s == ST_RINGING && state_r != ST_RINGING) begin
                sec_cnt_r <= 8'd0;
            end else if (state_r == ST_RINGING && sec_chg_s && !ring_done_s) begin
                sec_cnt_r <= sec_cnt_r + 8'd1;
            end
        end
    end

    alarm_tone_gen #(
        .TONE_DIV (TONE_DIV)
    ) u_tone (
        .clk  (clk),
        .rst  (rst),
        .en   (ringing_s),
        .tone (tone_s)
    );

    assign alm_hr  = alm_hr_r;
    assign alm_min = alm_min_r;
    assign ringing = ringing_s;
    assign snoozed = snoozed_s;
    assign buzzer  = tone_s & ringing_s & ~sec[0];

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: directed stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
    logic       set_mode, inc_hr_p, inc_min_p, arm, snooze_p, stop_p;
    logic [4:0] alm_hr;
    logic [5:0] alm_min;
    logic       ringing, snoozed, buzzer;

    int vectors = 0;
    int miscompares = 0;
    bit done = 1'b0;

    string       name_q[$];
    logic [13:0] exp_q[$];

    alarm_ctrl #(
        .TONE_DIV     (4),
        .RING_MAX_SEC (60),
        .SNOOZE_MIN   (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hr        (hr),
        .min       (min),
        .sec       (sec),
        .set_mode  (set_mode),
        .inc_hr_p  (inc_hr_p),
        .inc_min_p (inc_min_p),
        .arm       (arm),
        .snooze_p  (snooze_p),
        .stop_p    (stop_p),
        .alm_hr    (alm_hr),
        .alm_min   (alm_min),
        .ringing   (ringing),
        .snoozed   (snoozed),
        .buzzer    (buzzer)
    );

    always #5 clk = ~clk;

    // Monitor: compare the oldest pending expectation against the outputs
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            string       nm;
            logic [13:0] ev;
            logic [13:0] got;
            nm  = name_q.pop_front();
            ev  = exp_q.pop_front();
            got = {ringing, snoozed, buzzer, alm_hr, alm_min};
            vectors++;
            if (got !== ev) begin
                miscompares++;
                $display("FAIL %s: got ring=%b snz=%b buz=%b alm=%0d:%0d, want ring=%b snz=%b buz=%b alm=%0d:%0d",
                         nm, got[13], got[12], got[11], got[10:6], got[5:0],
                         ev[13], ev[12], ev[11], ev[10:6], ev[5:0]);
            end
        end
    end

    // Watchdog: the directed sequence must finish within a bounded time
    initial begin
        #200000;
        if (!done) begin
            miscompares++;
            $display("FAIL timeout: directed sequence did not complete");
            $finish;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_o(input string nm, input logic r, input logic s, input logic b,
                            input logic [4:0] ah, input logic [5:0] am);
        name_q.push_back(nm);
        exp_q.push_back({r, s, b, ah, am});
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_hr(input int n);
        for (int i = 0; i < n; i++) begin
            inc_hr_p = 1'b1;
            tick(1);
            inc_hr_p = 1'b0;
        end
    endtask

    task automatic pulse_min(input int n);
        for (int i = 0; i < n; i++) begin
            inc_min_p = 1'b1;
            tick(1);
            inc_min_p = 1'b0;
        end
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        hr = h; min = m; sec = s;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; set_mode = 1'b0;
        inc_hr_p = 1'b0; inc_min_p = 1'b0; snooze_p = 1'b0; stop_p = 1'b0;
        set_time(5'd0, 6'd0, 6'd0);
        tick(2);
        if ({ringing, snoozed, buzzer, alm_hr, alm_min} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_direct: ring=%b snz=%b buz=%b alm=%0d:%0d",
                     ringing, snoozed, buzzer, alm_hr, alm_min);
        end
        expect_o("reset", 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        rst = 1'b0;

        // Arming while the clock already equals the alarm must not ring
        arm = 1'b1;
        tick(3);
        expect_o("arm_on_match", 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);

        set_mode = 1'b1;
        pulse_hr(7);
        expect_o("edit_hr7", 1'b0, 1'b0, 1'b0, 5'd7, 6'd0);
        pulse_min(30);
        expect_o("edit_0730", 1'b0, 1'b0, 1'b0, 5'd7, 6'd30);
        set_mode = 1'b0;
        pulse_hr(1);
        expect_o("pulse_ignored", 1'b0, 1'b0, 1'b0, 5'd7, 6'd30);

        // Basic ring, tone cadence and stop
        set_time(5'd7, 6'd29, 6'd59);
        tick(2);
        expect_o("pre_match", 1'b0, 1'b0, 1'b0, 5'd7, 6'd30);
        set_time(5'd7, 6'd30, 6'd0);
        tick(1);
        expect_o("ring_0730", 1'b1, 1'b0, 1'b0, 5'd7, 6'd30);
        tick(4);
        expect_o("tone_high", 1'b1, 1'b0, 1'b1, 5'd7, 6'd30);
        tick(4);
        expect_o("tone_low", 1'b1, 1'b0, 1'b0, 5'd7, 6'd30);
        tick(4);
        sec = 6'd1;
        expect_o("tone_odd_sec", 1'b1, 1'b0, 1'b0, 5'd7, 6'd30);
        sec = 6'd2;
        expect_o("tone_even_sec", 1'b1, 1'b0, 1'b1, 5'd7, 6'd30);
        stop_p = 1'b1;
        tick(1);
        stop_p = 1'b0;
        expect_o("stop", 1'b0, 1'b0, 1'b0, 5'd7, 6'd30);
        tick(10);
        expect_o("no_rering", 1'b0, 1'b0, 1'b0, 5'd7, 6'd30);

        // stop_p beats snooze_p
        min = 6'd31;
        tick(1);
        min = 6'd30;
        tick(1);
        expect_o("ring_again", 1'b1, 1'b0, 1'b0, 5'd7, 6'd30);
        stop_p = 1'b1; snooze_p = 1'b1;
        tick(1);
        stop_p = 1'b0; snooze_p = 1'b0;
        expect_o("stop_beats_snooze", 1'b0, 1'b0, 1'b0, 5'd7, 6'd30);

        // Auto-stop after 60 second changes
        set_time(5'd7, 6'd31, 6'd0);
        tick(1);
        min = 6'd30;
        tick(1);
        expect_o("ring_autostop", 1'b1, 1'b0, 1'b0, 5'd7, 6'd30);
        for (int i = 1; i < 60; i++) begin
            sec = 6'(i);
            tick(1);
        end
        tick(2);
        expect_o("ring_59_changes", 1'b1, 1'b0, 1'b0, 5'd7, 6'd30);
        sec = 6'd0;
        tick(3);
        expect_o("autostop", 1'b0, 1'b0, 1'b0, 5'd7, 6'd30);

        // Edit wrap: hour mod 24, minute mod 60 without hour carry
        set_mode = 1'b1;
        pulse_hr(24);
        expect_o("hr_wrap24", 1'b0, 1'b0, 1'b0, 5'd7, 6'd30);
        pulse_hr(16);
        pulse_min(60);
        expect_o("min_wrap60", 1'b0, 1'b0, 1'b0, 5'd23, 6'd30);
        pulse_min(28);
        set_mode = 1'b0;
        expect_o("edit_2358", 1'b0, 1'b0, 1'b0, 5'd23, 6'd58);

        // Snooze across midnight: 23:58 + 5 -> 00:03
        set_time(5'd23, 6'd57, 6'd50);
        tick(2);
        set_time(5'd23, 6'd58, 6'd0);
        tick(1);
        expect_o("ring_2358", 1'b1, 1'b0, 1'b0, 5'd23, 6'd58);
        snooze_p = 1'b1;
        tick(1);
        snooze_p = 1'b0;
        expect_o("snooze", 1'b0, 1'b1, 1'b0, 5'd23, 6'd58);
        set_time(5'd0, 6'd2, 6'd59);
        tick(3);
        expect_o("snooze_hold", 1'b0, 1'b1, 1'b0, 5'd23, 6'd58);
        set_time(5'd0, 6'd3, 6'd0);
        tick(1);
        expect_o("snooze_ring_0003", 1'b1, 1'b0, 1'b0, 5'd23, 6'd58);

        // An edit during snooze cancels it
        snooze_p = 1'b1;
        tick(1);
        snooze_p = 1'b0;
        expect_o("snooze2", 1'b0, 1'b1, 1'b0, 5'd23, 6'd58);
        set_mode = 1'b1;
        pulse_min(1);
        set_mode = 1'b0;
        expect_o("edit_cancels_snooze", 1'b0, 1'b0, 1'b0, 5'd23, 6'd59);

        // Disarm during snooze
        set_time(5'd23, 6'd59, 6'd0);
        tick(1);
        expect_o("ring_2359", 1'b1, 1'b0, 1'b0, 5'd23, 6'd59);
        snooze_p = 1'b1;
        tick(1);
        snooze_p = 1'b0;
        expect_o("snooze3", 1'b0, 1'b1, 1'b0, 5'd23, 6'd59);
        arm = 1'b0;
        tick(1);
        expect_o("disarm_snooze", 1'b0, 1'b0, 1'b0, 5'd23, 6'd59);
        tick(2);
        arm = 1'b1;
        tick(2);
        expect_o("rearm_on_match", 1'b0, 1'b0, 1'b0, 5'd23, 6'd59);

        // Reset in the middle of ringing
        min = 6'd58;
        tick(1);
        min = 6'd59;
        tick(1);
        expect_o("ring_before_rst", 1'b1, 1'b0, 1'b0, 5'd23, 6'd59);
        tick(4);
        expect_o("buzz_before_rst", 1'b1, 1'b0, 1'b1, 5'd23, 6'd59);
        rst = 1'b1;
        set_time(5'd0, 6'd0, 6'd0);
        expect_o("rst_async", 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        tick(1);
        rst = 1'b0;
        tick(6);
        expect_o("no_ring_after_rst", 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);

        tick(2);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares != 0) begin
            $display("FAIL: %0d miscompares", miscompares);
        end else begin
            $display("PASS");
        end
        $finish;
    end

endmodule
